// File: rtl/wfg_memory_streamer.sv
// Sequential sample fetcher: walks a configurable address window of the sample
// memory and delivers the read words as a valid/ready stream through a small FIFO.
module wfg_memory_streamer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] cfg_start,
    input  logic [ADDR_W-1:0] cfg_end,
    output logic              csb,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dout,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              wrap
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] ptr_r, start_r, end_r;
    logic [ADDR_W-1:0] cur_ptr_s, cur_start_s, cur_end_s, ptr_nxt_s;
    logic              last_s, issue_s, push_s, pop_s, flush_s;
    logic              rd_pend_r;
    logic [CNT_W:0]    occ_s;
    logic [DATA_W-1:0] fifo_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, effective window (live config in IDLE) and read-issue credit
    always_comb begin
        state_s     = state_r;
        cur_ptr_s   = ptr_r;
        cur_start_s = start_r;
        cur_end_s   = end_r;
        case (state_r)
            IDLE: begin
                cur_ptr_s   = cfg_start;
                cur_start_s = cfg_start;
                cur_end_s   = cfg_end;
                if (en) state_s = FETCH;
                else    state_s = IDLE;
            end
            FETCH: begin
                if (en) state_s = FETCH;
                else    state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
        // Words buffered plus reads still travelling through the memory
        occ_s   = {1'b0, count_r} + {{CNT_W{1'b0}}, ~csb} + {{CNT_W{1'b0}}, rd_pend_r};
        issue_s = en && (occ_s < (CNT_W + 1)'(DEPTH));
        last_s  = (cur_ptr_s == cur_end_s);
        if (last_s) begin
            ptr_nxt_s = cur_start_s;
        end else begin
            ptr_nxt_s = cur_ptr_s + ADDR_W'(1);
        end
    end

    assign push_s  = rd_pend_r && en;
    assign pop_s   = tvalid && tready;
    assign flush_s = !en;
    assign tvalid  = (count_r != {CNT_W{1'b0}});
    assign tdata   = tvalid ? fifo_r[rd_ptr_r] : {DATA_W{1'b0}};

    // Memory read port, window pointer and wrap pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            csb       <= 1'b1;
            addr      <= {ADDR_W{1'b0}};
            wrap      <= 1'b0;
            rd_pend_r <= 1'b0;
            ptr_r     <= {ADDR_W{1'b0}};
            start_r   <= {ADDR_W{1'b0}};
            end_r     <= {ADDR_W{1'b0}};
        end else begin
            // A read captured by the memory now returns data next cycle unless stopping
            rd_pend_r <= en && !csb;
            if (state_r == IDLE && en) begin
                start_r <= cfg_start;
                end_r   <= cfg_end;
            end
            if (issue_s) begin
                csb   <= 1'b0;
                addr  <= cur_ptr_s;
                ptr_r <= ptr_nxt_s;
                wrap  <= last_s;
            end else begin
                csb   <= 1'b1;
                wrap  <= 1'b0;
            end
        end
    end

    // Output FIFO; flushed whenever streaming is disabled
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= dout;
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_wfg_memory_streamer.sv
// Directed bench for wfg_memory_streamer: a behavioural 1024x32 memory,
// table-driven window vectors and hand-written backpressure/stop/random sequences.
module tb_wfg_memory_streamer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [9:0]  cfg_start;
    logic [9:0]  cfg_end;
    logic        csb;
    logic [9:0]  addr;
    logic [31:0] dout;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1024];

    typedef struct {
        int       s;
        int       e;
        int       a [6];
        bit [5:0] w;
    } vec_t;

    vec_t vecs [4];

    wfg_memory_streamer #(.ADDR_W(10), .DATA_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_start (cfg_start),
        .cfg_end   (cfg_end),
        .csb       (csb),
        .addr      (addr),
        .dout      (dout),
        .tdata     (tdata),
        .tvalid    (tvalid),
        .tready    (tready),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: captures addr while csb is low, data valid the following cycle
    always @(posedge clk) begin
        if (!csb) dout <= mem[addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Streams words from window s..e; mode 0 tready=1, 1 random, 2 ten-cycle stall
    task automatic run_stream(input int s, input int e, input int n, input int mode);
        int          exp_a;
        int          got;
        int          cyc;
        int          stall;
        int          outstanding;
        bit          holding;
        bit          stall_chk;
        logic [31:0] held;
        exp_a = s; got = 0; cyc = 0; stall = 0; outstanding = 0;
        holding = 1'b0; stall_chk = 1'b0; held = 32'h0;
        cfg_start = 10'(s);
        cfg_end   = 10'(e);
        tready    = 1'b0;
        en        = 1'b1;
        while (got < n && cyc < n * 4 + 200) begin
            @(negedge clk);
            cyc++;
            if (!csb) outstanding++;
            chk("occupancy_le_depth", 32'(outstanding > 4), 32'd0);
            case (mode)
                0: tready = 1'b1;
                1: tready = 1'($urandom_range(0, 1));
                default: begin
                    if (got >= 3 && stall < 10) begin
                        tready = 1'b0;
                        stall++;
                    end else begin
                        if (stall == 10 && !stall_chk) begin
                            chk("stall_csb_idle", 32'(csb), 32'd1);
                            stall_chk = 1'b1;
                        end
                        tready = 1'b1;
                    end
                end
            endcase
            if (tvalid && tready) begin
                chk("stream_word", tdata, 32'hA000_0000 + 32'(exp_a));
                got++;
                outstanding--;
                holding = 1'b0;
                exp_a = (exp_a == e) ? s : (exp_a + 1) % 1024;
            end else if (tvalid) begin
                if (holding) chk("tdata_held", tdata, held);
                held    = tdata;
                holding = 1'b1;
            end else begin
                holding = 1'b0;
            end
        end
        chk("stream_timeout", 32'(got), 32'(n));
        en     = 1'b0;
        tready = 1'b1;
        @(negedge clk);
        chk("stop_tvalid", 32'(tvalid), 32'd0);
        chk("stop_csb", 32'(csb), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
        dout = 32'h0;

        vecs[0].s = 5;    vecs[0].e = 8; vecs[0].a = '{5, 6, 7, 8, 5, 6};
        vecs[0].w = 6'b001000;
        vecs[1].s = 1022; vecs[1].e = 1; vecs[1].a = '{1022, 1023, 0, 1, 1022, 1023};
        vecs[1].w = 6'b001000;
        vecs[2].s = 7;    vecs[2].e = 7; vecs[2].a = '{7, 7, 7, 7, 7, 7};
        vecs[2].w = 6'b111111;
        vecs[3].s = 0;    vecs[3].e = 2; vecs[3].a = '{0, 1, 2, 0, 1, 2};
        vecs[3].w = 6'b100100;

        // Reset held with en and tready asserted
        rst = 1'b1; en = 1'b1; tready = 1'b1;
        cfg_start = 10'd5; cfg_end = 10'd8;
        repeat (3) begin
            @(negedge clk);
            chk("rst_csb", 32'(csb), 32'd1);
            chk("rst_addr", 32'(addr), 32'd0);
            chk("rst_tvalid", 32'(tvalid), 32'd0);
            chk("rst_tdata", tdata, 32'd0);
            chk("rst_wrap", 32'(wrap), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_csb", 32'(csb), 32'd0);
        chk("post_rst_addr", 32'(addr), 32'd5);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Window vectors: latency, addr/wrap sequence and one word per cycle
        for (int v = 0; v < 4; v++) begin
            cfg_start = 10'(vecs[v].s);
            cfg_end   = 10'(vecs[v].e);
            tready    = 1'b1;
            en        = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (k < 6) begin
                    chk("vec_csb", 32'(csb), 32'd0);
                    chk("vec_addr", 32'(addr), 32'(vecs[v].a[k]));
                    chk("vec_wrap", 32'(wrap), 32'(vecs[v].w[k]));
                end
                if (k < 2) begin
                    chk("vec_latency_tvalid", 32'(tvalid), 32'd0);
                end else begin
                    chk("vec_tvalid", 32'(tvalid), 32'd1);
                    chk("vec_tdata", tdata, mem[vecs[v].a[k-2]]);
                end
            end
            en = 1'b0;
            @(negedge clk);
            chk("vec_stop_tvalid", 32'(tvalid), 32'd0);
            chk("vec_stop_csb", 32'(csb), 32'd1);
            chk("vec_stop_wrap", 32'(wrap), 32'd0);
            @(negedge clk);
        end

        // Backpressure: ten-cycle stall mid-stream
        run_stream(5, 8, 20, 2);

        // Stop with two words buffered and two reads in flight
        cfg_start = 10'd5; cfg_end = 10'd8;
        tready = 1'b0;
        en = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_stop_tvalid", 32'(tvalid), 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("stop_mid_tvalid", 32'(tvalid), 32'd0);
        chk("stop_mid_csb", 32'(csb), 32'd1);
        chk("stop_mid_addr_hold", 32'(addr), 32'd8);
        repeat (3) begin
            @(negedge clk);
            chk("stale_dropped", 32'(tvalid), 32'd0);
        end
        run_stream(20, 25, 8, 0);

        // Random backpressure across the full window
        run_stream(0, 1023, 2000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
